// File: rtl/audio_sample_collector.sv
// Pops paired left/right samples from the deserializer FIFOs, mixes them to mono and
// box-car decimates by 2^DECIM_LOG2 onto a valid/ready stream; also counts FIFO-full events.
module audio_sample_collector #(
    parameter int AUDIO_DATA_WIDTH = 16,
    parameter int DECIM_LOG2       = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_enable,
    input  logic [7:0]                  i_left_audio_fifo_read_space,
    input  logic [7:0]                  i_right_audio_fifo_read_space,
    input  logic [AUDIO_DATA_WIDTH:1]   i_left_channel_data,
    input  logic [AUDIO_DATA_WIDTH:1]   i_right_channel_data,
    output logic                        o_read_left_audio_data_en,
    output logic                        o_read_right_audio_data_en,
    output logic [AUDIO_DATA_WIDTH-1:0] o_sample_out,
    output logic                        o_sample_valid,
    input  logic                        i_sample_ready,
    output logic [15:0]                 o_full_event_count
);

    localparam int W  = AUDIO_DATA_WIDTH;
    localparam int SW = W + 1;
    localparam int AW = W + 1 + DECIM_LOG2;
    localparam int PW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'((1 << DECIM_LOG2) - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_POP     = 2'd1;
    localparam logic [1:0] S_SETTLE1 = 2'd2;
    localparam logic [1:0] S_SETTLE2 = 2'd3;

    logic [1:0]           r_state;
    logic signed [AW-1:0] r_acc;
    logic [PW-1:0]        r_phase;
    logic [W-1:0]         r_sample_out;
    logic                 r_sample_valid;
    logic [15:0]          r_full_count;
    logic                 r_prev_full_l;
    logic                 r_prev_full_r;

    logic                 w_avail_l;
    logic                 w_avail_r;
    logic                 w_start;
    logic                 w_pop;
    logic                 w_load;
    logic                 w_full_rise;
    logic signed [SW-1:0] w_sum;
    logic signed [AW-1:0] w_sum_ext;
    logic signed [AW-1:0] w_total;

    assign w_avail_l = (i_left_audio_fifo_read_space[6:0] != 7'd0) || i_left_audio_fifo_read_space[7];
    assign w_avail_r = (i_right_audio_fifo_read_space[6:0] != 7'd0) || i_right_audio_fifo_read_space[7];
    assign w_start   = i_enable && w_avail_l && w_avail_r && (!r_sample_valid || i_sample_ready);
    assign w_pop     = (r_state == S_POP);
    assign w_load    = w_pop && (r_phase == PHASE_LAST);

    assign w_sum     = $signed({i_left_channel_data[W], i_left_channel_data})
                     + $signed({i_right_channel_data[W], i_right_channel_data});
    assign w_sum_ext = AW'(w_sum);
    assign w_total   = r_acc + w_sum_ext;

    // Gated by reset so a FIFO is never popped while the collector is being cleared.
    assign o_read_left_audio_data_en  = w_pop && !reset;
    assign o_read_right_audio_data_en = w_pop && !reset;
    assign o_sample_out               = r_sample_out;
    assign o_sample_valid             = r_sample_valid;
    assign o_full_event_count         = r_full_count;

    // Two settle cycles let the lagging read_space reflect the pop before the next decision.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (w_start) r_state <= S_POP;
                S_POP:     r_state <= S_SETTLE1;
                S_SETTLE1: r_state <= S_SETTLE2;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc          <= '0;
            r_phase        <= '0;
            r_sample_out   <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            if (w_pop) begin
                if (w_load) begin
                    r_acc   <= '0;
                    r_phase <= '0;
                end else begin
                    r_acc   <= w_total;
                    r_phase <= r_phase + PW'(1);
                end
            end
            if (w_load) begin
                r_sample_out   <= W'(w_total >>> (DECIM_LOG2 + 1));
                r_sample_valid <= 1'b1;
            end else if (r_sample_valid && i_sample_ready) begin
                r_sample_valid <= 1'b0;
            end
        end
    end

    assign w_full_rise = (i_left_audio_fifo_read_space[7] && !r_prev_full_l)
                      || (i_right_audio_fifo_read_space[7] && !r_prev_full_r);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_full_l <= 1'b0;
            r_prev_full_r <= 1'b0;
            r_full_count  <= '0;
        end else begin
            r_prev_full_l <= i_left_audio_fifo_read_space[7];
            r_prev_full_r <= i_right_audio_fifo_read_space[7];
            if (w_full_rise && (r_full_count != 16'hFFFF))
                r_full_count <= r_full_count + 16'd1;
        end
    end

endmodule

// File: doc/audio_sample_collector.md
# audio_sample_collector

Downstream consumer of the audio-in deserializer's left/right sample FIFOs. Pops one left and one right sample together whenever both FIFOs hold data, and mixes them to mono. Box-car averages 2^DECIM_LOG2 mono samples and presents the decimated result to the DFT front end on a valid/ready stream. Applies back-pressure by not popping, and counts FIFO-full events for diagnostics.

## Interface
- AUDIO_DATA_WIDTH, 16, sample width W; two's complement in and out.
- DECIM_LOG2, 2, decimation factor is 2^DECIM_LOG2; legal range 0..6.
- clk  in  1  system clock, 50 MHz.
- reset  in  1  reset, synchronous, active-high.
- enable  in  1  allows new pops; sampled in IDLE only.
- left_audio_fifo_read_space  in  8  bit7 = left FIFO full, [6:0] = words used; registered one cycle behind the FIFO.
- right_audio_fifo_read_space  in  8  same, right FIFO.
- left_channel_data  in  [W:1]  left FIFO head word, show-ahead (valid while words used > 0 or full).
- right_channel_data  in  [W:1]  right FIFO head word, show-ahead.
- read_left_audio_data_en  out  1  pop left FIFO, one-cycle pulse.
- read_right_audio_data_en  out  1  pop right FIFO, one-cycle pulse.
- sample_out  out  W  decimated mono sample, signed.
- sample_valid  out  1  sample_out holds an unconsumed sample.
- sample_ready  in  1  consumer accepts on the cycle where sample_valid & sample_ready.
- full_event_count  out  16  saturating count of rising edges of either FIFO-full flag.

## Operation
- "Available" for a channel: read_space[6:0] != 0 or read_space[7] == 1.
- FSM states: IDLE, POP, SETTLE1, SETTLE2.
- IDLE -> POP when all of the following hold: enable, both channels available, and the output register is free (sample_valid == 0, or sample_ready == 1 this cycle).
- POP: assert both read enables for exactly one cycle. Capture both head words in the same cycle. Go to SETTLE1.
- SETTLE1 -> SETTLE2 -> IDLE unconditionally. These two cycles cover the read_space register lag so an emptied FIFO is never popped twice.
- Mix in POP: sum = sext(L) + sext(R), W+1 bits. No divide at this point.
- Accumulator: W+1+DECIM_LOG2 bits, signed; never overflows.
- Phase counter: DECIM_LOG2 bits.
- In POP, if phase == 2^DECIM_LOG2−1:
  - sample_out <= (acc + sum) >>> (DECIM_LOG2+1), arithmetic shift, floor rounding, truncated to W bits (always in range).
  - sample_valid <= 1; acc <= 0; phase <= 0.
- Otherwise in POP: acc <= acc + sum; phase <= phase + 1. Phase wraps naturally.
- DECIM_LOG2 = 0: every pop emits (L+R) >>> 1.
- Output register: sample_valid clears on a handshake unless a new sample loads in the same cycle. A load and a handshake in the same cycle leaves valid at 1 with the new data.
- Back-pressure: while sample_valid & !sample_ready, no pop starts. The FIFOs absorb the stall; the upstream block drops samples once its FIFO is full.
- full_event_count increments on any 0->1 transition of left bit7 or right bit7, previous values registered. Both rising in the same cycle counts +1. Saturates at 0xFFFF.
- enable low: a pop/settle already in progress completes. Accumulator and phase are retained, so decimation resumes seamlessly.

## Timing
- Reset values: read enables 0, sample_out 0, sample_valid 0, full_event_count 0, acc 0, phase 0, FSM IDLE, previous-full registers 0.
- Reset asserted mid-sequence: everything returns to the reset values on the next clock. No read enable fires during or on the cycle after reset.
- Minimum pop spacing is 4 cycles (IDLE, POP, SETTLE1, SETTLE2), far above the 48 kHz pair rate.
- Latency: sample_valid rises on the clock edge ending the POP cycle that completes a group, i.e. 1 cycle after the final pop.
- The left and right read enables are always asserted in the same cycle; one without the other is never asserted.
- Only one channel available: no pop, wait indefinitely.

## Test plan
- DECIM_LOG2=2, four pairs L=100, R=300, sample_ready=1 -> exactly four paired pops 4 cycles apart; single sample_out=200 with a one-cycle sample_valid pulse.
- DECIM_LOG2=2, four pairs L=−1, R=−2 -> sample_out=−2 (0xFFFE), confirming floor rounding.
- DECIM_LOG2=0, L=0x7FFF, R=0x7FFF, then L=0x8000, R=0x8000 -> outputs 0x7FFF then 0x8000; no overflow.
- DECIM_LOG2=0, sample_ready=0, five pairs queued -> one pop, sample_valid held with data stable. After raising sample_ready: one pop per accept; FIFO contents drain in order.
- Right FIFO empty, left has 3 words -> no read enable ever asserted. Left-full flag toggles 0->1 twice -> full_event_count=2.
- Reset pulsed during SETTLE1 with acc nonzero -> all outputs 0 next cycle; the next group averages only post-reset samples.
